// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, default frame configuration, line constants.
package uart_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_PARITY_EN  = 0;
    localparam int unsigned DEF_PARITY_ODD = 0;
    localparam int unsigned DEF_STOP_BITS  = 1;

    // Counter widths cover DATA_BITS up to 9 and STOP_BITS up to 2.
    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned STOP_CNT_W = 2;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Rising-edge detector turning the prescaler's baud level into a one-cycle tick.
module uart_baud_tick (
    input  logic src_clk,
    input  logic rst_n,
    input  logic Uart_clk,
    output logic baud_tick_c
);

    logic clk_q;

    // Delayed copy of the baud level for edge detection.
    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            clk_q <= 1'b0;
        end else begin
            clk_q <= Uart_clk;
        end
    end

    assign baud_tick_c = Uart_clk & ~clk_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: valid/ready word in, LSB-first start/data/parity/stop frame out.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned PARITY_EN  = DEF_PARITY_EN,
    parameter int unsigned PARITY_ODD = DEF_PARITY_ODD,
    parameter int unsigned STOP_BITS  = DEF_STOP_BITS
) (
    input  logic                 src_clk,
    input  logic                 rst_n,
    input  logic                 Uart_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    logic                  baud_tick_c;
    logic [STATE_W-1:0]    state_q,    state_d;
    logic                  tx_q,       tx_d;
    logic                  ready_q,    ready_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic [DATA_BITS-1:0]  shift_q,    shift_d;
    logic                  par_q,      par_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [STOP_CNT_W-1:0] stop_cnt_q, stop_cnt_d;

    uart_baud_tick u_baud_tick (
        .src_clk     (src_clk),
        .rst_n       (rst_n),
        .Uart_clk    (Uart_clk),
        .baud_tick_c (baud_tick_c)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_q       <= LINE_IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    // Next-state and next-output logic; everything but the accept waits for a baud tick.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ 1'(PARITY_ODD);
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (baud_tick_c) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick_c) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick_c) begin
                    if (bit_cnt_q < BIT_CNT_W'(DATA_BITS - 1)) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (PARITY_EN != 0) begin
                        tx_d    = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d       = LINE_IDLE;
                        stop_cnt_d = '0;
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick_c) begin
                    tx_d       = LINE_IDLE;
                    stop_cnt_d = '0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick_c) begin
                    if (stop_cnt_q == STOP_CNT_W'(STOP_BITS - 1)) begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + STOP_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1, 8E2 and 8O2 instances sharing clock, reset and baud level.
module tb_uart_tx;

    logic       src_clk  = 1'b0;
    logic       rst_n    = 1'b0;
    logic       Uart_clk = 1'b0;
    logic       baud_en  = 1'b1;
    int         baud_cnt = 0;
    logic [7:0] tx_data  = 8'h00;
    logic [2:0] valid_v  = 3'b000;
    logic [2:0] ready_v, tx_v, busy_v, done_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 src_clk = ~src_clk;

    // Baud level: 16 src_clk period, 8 high / 8 low; held low while disabled.
    always @(negedge src_clk) begin
        if (!baud_en) begin
            baud_cnt = 0;
            Uart_clk = 1'b0;
        end else begin
            Uart_clk = (baud_cnt < 8);
            baud_cnt = (baud_cnt + 1) % 16;
        end
    end

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .src_clk(src_clk), .rst_n(rst_n), .Uart_clk(Uart_clk), .tx_data(tx_data),
        .tx_valid(valid_v[0]), .tx_ready(ready_v[0]), .tx(tx_v[0]),
        .tx_busy(busy_v[0]), .tx_done(done_v[0]));

    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .src_clk(src_clk), .rst_n(rst_n), .Uart_clk(Uart_clk), .tx_data(tx_data),
        .tx_valid(valid_v[1]), .tx_ready(ready_v[1]), .tx(tx_v[1]),
        .tx_busy(busy_v[1]), .tx_done(done_v[1]));

    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .src_clk(src_clk), .rst_n(rst_n), .Uart_clk(Uart_clk), .tx_data(tx_data),
        .tx_valid(valid_v[2]), .tx_ready(ready_v[2]), .tx(tx_v[2]),
        .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word for a single cycle and confirm it was taken.
    task automatic send(input int sel, input logic [7:0] d);
        @(negedge src_clk);
        tx_data      = d;
        valid_v[sel] = 1'b1;
        @(negedge src_clk);
        valid_v[sel] = 1'b0;
        chk("accept_busy", 32'(busy_v[sel]), 32'd1);
        chk("accept_ready", 32'(ready_v[sel]), 32'd0);
    endtask

    task automatic wait_start(input int sel, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge src_clk);
            if (tx_v[sel] === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Check every cycle of a frame against its expected line bits (bit 0 = start bit).
    task automatic check_frame(input string tag, input int sel, input logic [11:0] exp_bits,
                               input int nbits, input bit b2b, input logic [7:0] nxt);
        bit seen;
        int errs, done_cnt, done_at;
        logic rdy_end, tx_end;
        wait_start(sel, seen);
        chk({tag, "_start"}, 32'(seen), 32'd1);
        if (!seen) return;
        errs = 0; done_cnt = 0; done_at = -1; rdy_end = 1'b0; tx_end = 1'b0;
        for (int j = 0; j <= 16 * nbits; j++) begin
            if (j > 0) @(negedge src_clk);
            if (j < 16 * nbits && tx_v[sel] !== exp_bits[j / 16]) errs++;
            if (done_v[sel] === 1'b1) begin
                done_cnt++;
                done_at = j;
            end
            if (j == 16 * nbits) begin
                rdy_end = ready_v[sel];
                tx_end  = tx_v[sel];
                if (b2b) begin
                    tx_data      = nxt;
                    valid_v[sel] = 1'b1;
                end
            end
        end
        chk({tag, "_line"}, 32'(errs), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_at"}, 32'(done_at), 32'(16 * nbits));
        chk({tag, "_ready_end"}, 32'(rdy_end), 32'd1);
        chk({tag, "_tx_end"}, 32'(tx_end), 32'd1);
        @(negedge src_clk);
        chk({tag, "_done_width"}, 32'(done_v[sel]), 32'd0);
        if (b2b) begin
            valid_v[sel] = 1'b0;
            chk({tag, "_b2b_busy"}, 32'(busy_v[sel]), 32'd1);
        end
    endtask

    initial begin
        bit seen;
        int errs;

        // 1: reset values
        repeat (3) @(negedge src_clk);
        chk("rst_tx", 32'(tx_v), 32'h7);
        chk("rst_ready", 32'(ready_v), 32'h7);
        chk("rst_busy", 32'(busy_v), 32'h0);
        chk("rst_done", 32'(done_v), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge src_clk);

        // 2: 8N1 0xA5
        send(0, 8'hA5);
        check_frame("a5", 0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 8'h00);

        // 3: parity even / odd with two stop bits
        send(1, 8'h07);
        check_frame("p_even", 1, {2'b11, 1'b1, 8'h07, 1'b0}, 12, 1'b0, 8'h00);
        send(2, 8'h07);
        check_frame("p_odd", 2, {2'b11, 1'b0, 8'h07, 1'b0}, 12, 1'b0, 8'h00);

        // 4: intruding valid mid-frame, then back-to-back frame
        send(0, 8'h3C);
        fork
            check_frame("x3c", 0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1'b1, 8'h96);
            begin
                bit s2;
                wait_start(0, s2);
                if (s2) begin
                    repeat (52) @(negedge src_clk);
                    tx_data    = 8'hFF;
                    valid_v[0] = 1'b1;
                    repeat (8) @(negedge src_clk);
                    chk("intrude_ready", 32'(ready_v[0]), 32'd0);
                    valid_v[0] = 1'b0;
                end
            end
        join
        check_frame("x96", 0, {2'b00, 1'b1, 8'h96, 1'b0}, 10, 1'b0, 8'h00);

        // 5: reset during data bit 3
        send(0, 8'hC3);
        wait_start(0, seen);
        chk("mid_start", 32'(seen), 32'd1);
        repeat (68) @(negedge src_clk);
        rst_n = 1'b0;
        @(negedge src_clk);
        chk("mid_rst_tx", 32'(tx_v[0]), 32'd1);
        chk("mid_rst_ready", 32'(ready_v[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        chk("mid_rst_done", 32'(done_v[0]), 32'd0);
        repeat (2) @(negedge src_clk);
        rst_n = 1'b1;
        errs = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge src_clk);
            if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) errs++;
        end
        chk("post_rst_quiet", 32'(errs), 32'd0);
        send(0, 8'h55);
        check_frame("x55", 0, {2'b00, 1'b1, 8'h55, 1'b0}, 10, 1'b0, 8'h00);

        // 6: stalled baud level holds the frame
        baud_en = 1'b0;
        repeat (2) @(negedge src_clk);
        send(0, 8'h81);
        errs = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge src_clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) errs++;
        end
        chk("stall_hold", 32'(errs), 32'd0);
        baud_en = 1'b1;
        check_frame("x81", 0, {2'b00, 1'b1, 8'h81, 1'b0}, 10, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
